// File: rtl/score_scan_sequencer_if.sv
// Score-stream bus between the scan sequencer and its controller / score consumer.
// Controller side drives frame start and weight writes; sequencer drives the stream.
interface score_scan_sequencer_if #(
    parameter int unsigned NUM_IN     = 8,
    parameter int unsigned NUM_NEURON = 4,
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned IIDX_W     = 3,
    parameter int unsigned NIDX_W     = 2
) ();
    logic                start;
    logic [NUM_IN-1:0]   spike_vec;
    logic                busy;
    logic                w_we;
    logic [NIDX_W-1:0]   w_neuron;
    logic [IIDX_W-1:0]   w_input;
    logic [SCORE_W-1:0]  w_data;
    logic                scan_start_en;
    logic                score_valid;
    logic [SCORE_W-1:0]  score_in;
    logic [NIDX_W-1:0]   neuron_idx;
    logic                scan_done;
    logic                frame_done;

    modport master (
        output start, spike_vec, w_we, w_neuron, w_input, w_data,
        input  busy, scan_start_en, score_valid, score_in, neuron_idx, scan_done, frame_done
    );

    modport slave (
        input  start, spike_vec, w_we, w_neuron, w_input, w_data,
        output busy, scan_start_en, score_valid, score_in, neuron_idx, scan_done, frame_done
    );
endinterface

// File: rtl/score_scan_sequencer.sv
// Scans each neuron's weight row against a latched spike vector and emits one score
// per input, framed by a clear strobe before and a done pulse after every scan.
module score_scan_sequencer #(
    parameter int unsigned NUM_IN     = 8,
    parameter int unsigned NUM_NEURON = 4,
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned IIDX_W     = 3,
    parameter int unsigned NIDX_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    score_scan_sequencer_if.slave bus
);

    localparam logic [IIDX_W-1:0] LAST_I = IIDX_W'(NUM_IN - 1);
    localparam logic [NIDX_W-1:0] LAST_N = NIDX_W'(NUM_NEURON - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [NIDX_W-1:0]    n_q;
    logic [NIDX_W-1:0]    n_next;
    logic [IIDX_W-1:0]    i_q;
    logic [IIDX_W-1:0]    i_next;
    logic [NUM_IN-1:0]    spike_q;
    logic [NUM_IN-1:0]    spike_next;
    logic [SCORE_W-1:0]   w_q [NUM_NEURON][NUM_IN];
    logic                 w_ok;

    logic                 busy_q;
    logic                 scan_start_en_q;
    logic                 score_valid_q;
    logic [SCORE_W-1:0]   score_in_q;
    logic [NIDX_W-1:0]    neuron_idx_q;
    logic                 scan_done_q;
    logic                 frame_done_q;

    logic                 busy_c;
    logic                 scan_start_en_c;
    logic                 score_valid_c;
    logic [SCORE_W-1:0]   score_in_c;
    logic [NIDX_W-1:0]    neuron_idx_c;
    logic                 scan_done_c;
    logic                 frame_done_c;

    // State, counters and latched spikes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            spike_q <= '0;
        end else begin
            state   <= state_next;
            n_q     <= n_next;
            i_q     <= i_next;
            spike_q <= spike_next;
        end
    end

    // Next-state and counter sequencing
    always_comb begin
        state_next = state;
        n_next     = n_q;
        i_next     = i_q;
        spike_next = spike_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    spike_next = bus.spike_vec;
                    n_next     = '0;
                    i_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                i_next     = '0;
                state_next = SCAN;
            end
            SCAN: begin
                if (i_q == LAST_I) begin
                    state_next = DONE;
                end else begin
                    i_next = i_q + IIDX_W'(1);
                end
            end
            DONE: begin
                if (n_q == LAST_N) begin
                    n_next     = '0;
                    state_next = IDLE;
                end else begin
                    n_next     = n_q + NIDX_W'(1);
                    state_next = START;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the upcoming state so they land registered in that state's cycle
    always_comb begin
        busy_c          = 1'b0;
        scan_start_en_c = 1'b0;
        score_valid_c   = 1'b0;
        score_in_c      = '0;
        neuron_idx_c    = '0;
        scan_done_c     = 1'b0;
        frame_done_c    = 1'b0;
        case (state_next)
            START: begin
                busy_c          = 1'b1;
                scan_start_en_c = 1'b1;
                neuron_idx_c    = n_next;
            end
            SCAN: begin
                busy_c        = 1'b1;
                score_valid_c = 1'b1;
                neuron_idx_c  = n_next;
                if (spike_next[i_next]) begin
                    score_in_c = w_q[n_next][i_next];
                end
            end
            DONE: begin
                busy_c       = 1'b1;
                neuron_idx_c = n_next;
                scan_done_c  = 1'b1;
                frame_done_c = (n_next == LAST_N);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q          <= 1'b0;
            scan_start_en_q <= 1'b0;
            score_valid_q   <= 1'b0;
            score_in_q      <= '0;
            neuron_idx_q    <= '0;
            scan_done_q     <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            busy_q          <= busy_c;
            scan_start_en_q <= scan_start_en_c;
            score_valid_q   <= score_valid_c;
            score_in_q      <= score_in_c;
            neuron_idx_q    <= neuron_idx_c;
            scan_done_q     <= scan_done_c;
            frame_done_q    <= frame_done_c;
        end
    end

    // Weight table: writable only while idle, out-of-range indices dropped
    assign w_ok = ({1'b0, bus.w_neuron} < (NIDX_W + 1)'(NUM_NEURON)) &&
                  ({1'b0, bus.w_input}  < (IIDX_W + 1)'(NUM_IN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int nn = 0; nn < int'(NUM_NEURON); nn++) begin
                for (int ii = 0; ii < int'(NUM_IN); ii++) begin
                    w_q[nn][ii] <= '0;
                end
            end
        end else if (bus.w_we && !busy_q && w_ok) begin
            w_q[bus.w_neuron][bus.w_input] <= bus.w_data;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.scan_start_en = scan_start_en_q;
    assign bus.score_valid   = score_valid_q;
    assign bus.score_in      = score_in_q;
    assign bus.neuron_idx    = neuron_idx_q;
    assign bus.scan_done     = scan_done_q;
    assign bus.frame_done    = frame_done_q;

endmodule

// File: tb/tb_score_scan_sequencer.sv
// Directed bench for score_scan_sequencer: cycle-exact stream checks plus a reference
// accumulator whose sum is compared with hand-computed values at every scan_done.
module tb_score_scan_sequencer;

    logic clk;
    logic rst_n;

    score_scan_sequencer_if #(
        .NUM_IN(8), .NUM_NEURON(4), .SCORE_W(4), .IIDX_W(3), .NIDX_W(2)
    ) ifc ();

    score_scan_sequencer #(
        .NUM_IN(8), .NUM_NEURON(4), .SCORE_W(4), .IIDX_W(3), .NIDX_W(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int          n_checks;
    int          n_fail;
    logic [3:0]  tbw [4][8];
    logic [7:0]  acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference accumulator: cleared by the strobe, sums scores while valid
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 acc <= '0;
        else if (ifc.scan_start_en) acc <= '0;
        else if (ifc.score_valid)   acc <= acc + 8'(ifc.score_in);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic b, input logic sse, input logic v,
                                         input logic [3:0] s, input logic [1:0] ni,
                                         input logic sd, input logic fd);
        return 32'({b, sse, v, s, ni, sd, fd});
    endfunction

    function automatic logic [31:0] observed();
        return pack(ifc.busy, ifc.scan_start_en, ifc.score_valid, ifc.score_in,
                    ifc.neuron_idx, ifc.scan_done, ifc.frame_done);
    endfunction

    task automatic write_w(input int n, input int i, input logic [3:0] d);
        ifc.w_we     = 1'b1;
        ifc.w_neuron = 2'(n);
        ifc.w_input  = 3'(i);
        ifc.w_data   = d;
        @(negedge clk);
        ifc.w_we     = 1'b0;
        tbw[n][i]    = d;
    endtask

    task automatic clear_model();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 8; i++)
                tbw[n][i] = 4'd0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after DONE
    task automatic run_frame(input logic [7:0] spk, input int sums [4], input int inj, input int abort);
        logic [3:0] s;
        int         k;
        ifc.start     = 1'b1;
        ifc.spike_vec = spk;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int n = 0; n < 4; n++) begin
            for (int p = 0; p < 10; p++) begin
                k = n * 10 + p;
                s = 4'd0;
                if (p >= 1 && p <= 8 && spk[p-1]) s = tbw[n][p-1];
                check_eq($sformatf("vec k%0d", k), observed(),
                         pack(1'b1, p == 0, p >= 1 && p <= 8, s, 2'(n), p == 9, p == 9 && n == 3));
                if (p == 9) check_eq($sformatf("sum n%0d", n), 32'(acc), 32'(sums[n]));
                if (k == abort) begin
                    #2 rst_n = 1'b0;
                    #1 check_eq("rst_async", observed(), 32'd0);
                    repeat (2) begin
                        @(negedge clk);
                        check_eq("rst_hold", observed(), 32'd0);
                    end
                    rst_n = 1'b1;
                    clear_model();
                    @(negedge clk);
                    check_eq("rst_idle", observed(), 32'd0);
                    return;
                end
                if (k == inj) begin
                    ifc.start     = 1'b1;
                    ifc.spike_vec = ~spk;
                    ifc.w_we      = 1'b1;
                    ifc.w_neuron  = 2'd1;
                    ifc.w_input   = 3'd0;
                    ifc.w_data    = 4'd9;
                end else begin
                    ifc.start = 1'b0;
                    ifc.w_we  = 1'b0;
                end
                @(negedge clk);
            end
        end
        ifc.start = 1'b0;
        ifc.w_we  = 1'b0;
        check_eq("idle_after", observed(), 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        ifc.start     = 1'b0;
        ifc.spike_vec = '0;
        ifc.w_we      = 1'b0;
        ifc.w_neuron  = '0;
        ifc.w_input   = '0;
        ifc.w_data    = '0;
        clear_model();
        repeat (2) @(negedge clk);
        check_eq("reset_state", observed(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset", observed(), 32'd0);

        // w[n][i] = n+i, spikes on inputs 0,2,5,7 -> 4n+14
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 8; i++)
                write_w(n, i, 4'(n + i));
        run_frame(8'b1010_0101, '{14, 18, 22, 26}, -1, -1);
        repeat (2) @(negedge clk);

        run_frame(8'h00, '{0, 0, 0, 0}, -1, -1);
        repeat (2) @(negedge clk);

        // Mid-frame start and weight write must both be ignored
        run_frame(8'b1010_0101, '{14, 18, 22, 26}, 13, -1);
        // Back-to-back frame reads w[1][0] through neuron 1's sum
        run_frame(8'h01, '{0, 1, 2, 3}, -1, -1);
        repeat (2) @(negedge clk);

        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 8; i++)
                write_w(n, i, 4'd15);
        run_frame(8'hFF, '{120, 120, 120, 120}, -1, -1);
        repeat (2) @(negedge clk);

        // Reset during neuron 2 scan, then weights must read back as zero
        run_frame(8'hFF, '{120, 120, 120, 120}, -1, 24);
        @(negedge clk);
        run_frame(8'hFF, '{0, 0, 0, 0}, -1, -1);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
